// File: rtl/regfile_dump_ctrl_pkg.sv
// Shared debug definitions for the register-file dump controller: state encoding,
// TX byte width and the per-register byte count.
package regfile_dump_ctrl_pkg;

  localparam int unsigned NB_BYTE       = 8;
  localparam int unsigned NB_DATA_DFLT  = 32;
  localparam int unsigned BYTES_PER_REG = NB_DATA_DFLT / NB_BYTE;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_SEND  = 3'd2,
    ST_CSUM  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Byte count for a register width other than the default.
  function automatic int unsigned bytes_per_reg(input int unsigned nb_data);
    return nb_data / NB_BYTE;
  endfunction

endpackage

// File: rtl/regfile_dump_ctrl.sv
// Streams every general-purpose register, LSB first, to the debug UART TX while halted.
// Optional trailing XOR checksum byte when REGFILE_DUMP_CHECKSUM_EN is defined.
module regfile_dump_ctrl
  import regfile_dump_ctrl_pkg::*;
#(
  parameter int unsigned NB_DATA = 32,
  parameter int unsigned NB_ADDR = 5
) (
  input  logic               clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_halted,
  output logic [NB_ADDR-1:0] o_rf_addr,
  input  logic [NB_DATA-1:0] i_rf_data,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready,
  output logic               o_busy,
  output logic               o_done
);

  localparam int unsigned N_BYTES = bytes_per_reg(NB_DATA);
  localparam int unsigned NB_BIDX = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [NB_ADDR-1:0] LAST_REG = '1;
  localparam logic [NB_BIDX-1:0] LAST_BYTE = NB_BIDX'(N_BYTES - 1);

  state_t                            state, state_n;
  logic [NB_ADDR-1:0]                rf_addr_n;
  logic [NB_BIDX-1:0]                byte_idx, byte_idx_n;
  logic [NB_DATA-1:0]                capture, capture_n;
  logic [NB_BYTE-1:0]                tx_data_n;
  logic                              tx_valid_n;
  logic                              busy_n;
  logic                              done_n;
  logic [N_BYTES-1:0][NB_BYTE-1:0]   cap_bytes;

  assign cap_bytes = capture;

`ifdef REGFILE_DUMP_CHECKSUM_EN
  logic [NB_BYTE-1:0] csum, csum_n;
  logic [NB_BYTE-1:0] cur_byte;

  assign cur_byte = cap_bytes[byte_idx];

  // Running XOR of every data byte accepted by the transmitter.
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) csum <= '0;
    else          csum <= csum_n;
  end
`endif

  // State and registered outputs.
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      state      <= ST_IDLE;
      o_rf_addr  <= '0;
      byte_idx   <= '0;
      capture    <= '0;
      o_tx_data  <= '0;
      o_tx_valid <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      state      <= state_n;
      o_rf_addr  <= rf_addr_n;
      byte_idx   <= byte_idx_n;
      capture    <= capture_n;
      o_tx_data  <= tx_data_n;
      o_tx_valid <= tx_valid_n;
      o_busy     <= busy_n;
      o_done     <= done_n;
    end
  end

  // Next state plus next values of every registered output.
  always_comb begin
    state_n    = state;
    rf_addr_n  = o_rf_addr;
    byte_idx_n = byte_idx;
    capture_n  = capture;
    tx_data_n  = o_tx_data;
    tx_valid_n = o_tx_valid;
    busy_n     = o_busy;
    done_n     = 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    csum_n     = csum;
`endif

    unique case (state)
      ST_IDLE: begin
        busy_n     = 1'b0;
        tx_valid_n = 1'b0;
        rf_addr_n  = '0;
        // A start without halt is dropped rather than remembered.
        if (i_start && i_halted) begin
          state_n    = ST_FETCH;
          busy_n     = 1'b1;
          byte_idx_n = '0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
          csum_n     = '0;
`endif
        end
      end

      ST_FETCH: begin
        capture_n  = i_rf_data;
        byte_idx_n = '0;
        tx_data_n  = i_rf_data[NB_BYTE-1:0];
        tx_valid_n = 1'b1;
        state_n    = ST_SEND;
      end

      ST_SEND: begin
        if (i_tx_ready) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
          csum_n = csum ^ cur_byte;
`endif
          if (byte_idx == LAST_BYTE) begin
            if (o_rf_addr == LAST_REG) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
              state_n   = ST_CSUM;
              tx_data_n = csum ^ cur_byte;
`else
              state_n    = ST_DONE;
              tx_valid_n = 1'b0;
              done_n     = 1'b1;
`endif
            end else begin
              state_n    = ST_FETCH;
              tx_valid_n = 1'b0;
              rf_addr_n  = o_rf_addr + NB_ADDR'(1);
            end
          end else begin
            byte_idx_n = byte_idx + NB_BIDX'(1);
            tx_data_n  = cap_bytes[byte_idx + NB_BIDX'(1)];
          end
        end
      end

`ifdef REGFILE_DUMP_CHECKSUM_EN
      ST_CSUM: begin
        if (i_tx_ready) begin
          state_n    = ST_DONE;
          tx_valid_n = 1'b0;
          done_n     = 1'b1;
        end
      end
`endif

      ST_DONE: begin
        state_n = ST_IDLE;
        busy_n  = 1'b0;
      end

      default: begin
        state_n    = ST_IDLE;
        busy_n     = 1'b0;
        tx_valid_n = 1'b0;
      end
    endcase
  end

endmodule
